// File: rtl/cpumc_banked.sv
`default_nettype none
// ============================================================================
// Module      : cpumc_banked
// Description : NES CPU-side memory controller. Decodes the 16-bit CPU bus
//               into mirrored internal RAM, a forwarded PPU/APU I/O window
//               and UxROM-style banked PRG-ROM held in on-chip RAM. A loader
//               mode lets the host download PRG-ROM through the same bus.
//               Optional macro CPUMC_WRAM_EN adds 8 KB work RAM at
//               0x6000-0x7FFF; without it that range is unmapped.
// Revision    : 1.0 - initial release
// ============================================================================
module cpumc_banked #(
  parameter int PRG_BANK_BITS  = 1,
  parameter int RAM_ADDR_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [15:0]              addr,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     dvalid,
  input  logic                     prg_load,
  input  logic [PRG_BANK_BITS-1:0] load_bank,
  output logic                     io_rd,
  output logic                     io_wr,
  input  logic [7:0]               io_din
);

  localparam int PRG_AW = 14 + PRG_BANK_BITS;
  localparam logic [PRG_BANK_BITS-1:0] LAST_BANK = '1;

  logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH) - 1];
  logic [7:0] rom [0:(1 << PRG_AW) - 1];
`ifdef CPUMC_WRAM_EN
  logic [7:0] wram [0:8191];
`endif

  logic [PRG_BANK_BITS-1:0] bank_reg;
  logic [7:0]               rd_data;

  // Region decode
  logic is_ram, is_io, is_prg;
  assign is_ram = (addr[15:13] == 3'b000);
  assign is_io  = (addr >= 16'h2000) && (addr <= 16'h401F);
  assign is_prg = addr[15];
`ifdef CPUMC_WRAM_EN
  logic is_wram;
  assign is_wram = (addr[15:13] == 3'b011);
`endif

  // Upper half of PRG space always maps to the last bank, both for CPU
  // reads and for loader writes; the lower half uses bank_reg / load_bank.
  logic [PRG_AW-1:0] prg_addr;
  logic [PRG_AW-1:0] load_addr;
  assign prg_addr  = {(addr[14] ? LAST_BANK : bank_reg),  addr[13:0]};
  assign load_addr = {(addr[14] ? LAST_BANK : load_bank), addr[13:0]};

  // A read colliding with a write is dropped; nothing is accepted in reset.
  logic rd_acc, wr_acc;
  assign rd_acc = rd & ~wr & ~rst;
  assign wr_acc = wr & ~rst;

  assign io_rd = rd_acc & is_io;
  assign io_wr = wr_acc & is_io;

  // Read data mux; unmapped regions read as zero
  always_comb begin
    rd_data = 8'h00;
    if (is_ram) begin
      rd_data = ram[addr[RAM_ADDR_WIDTH-1:0]];
    end else if (is_io) begin
      rd_data = io_din;
`ifdef CPUMC_WRAM_EN
    end else if (is_wram) begin
      rd_data = wram[addr[12:0]];
`endif
    end else if (is_prg) begin
      rd_data = rom[prg_addr];
    end
  end

  // Internal RAM write port (mirrored by address truncation)
  always_ff @(posedge clk) begin
    if (wr_acc && is_ram) begin
      ram[addr[RAM_ADDR_WIDTH-1:0]] <= din;
    end
  end

  // PRG-ROM is writable only through the loader
  always_ff @(posedge clk) begin
    if (wr_acc && is_prg && prg_load) begin
      rom[load_addr] <= din;
    end
  end

`ifdef CPUMC_WRAM_EN
  // Work RAM accepts writes in either mode
  always_ff @(posedge clk) begin
    if (wr_acc && is_wram) begin
      wram[addr[12:0]] <= din;
    end
  end
`endif

  // UxROM bank select: CPU writes to PRG space latch the low din bits
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_reg <= '0;
    end else if (wr_acc && is_prg && !prg_load) begin
      bank_reg <= din[PRG_BANK_BITS-1:0];
    end
  end

  // Registered read return with a one-cycle valid strobe; dout holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= 8'h00;
      dvalid <= 1'b0;
    end else begin
      dvalid <= rd_acc;
      if (rd_acc) begin
        dout <= rd_data;
      end
    end
  end

endmodule
`default_nettype wire
